// File: rtl/adder_arbiter_pkg.sv
// Shared types for the adder arbiter slice: datapath width, FSM state
// encoding and the requester-ID width helper.
package adder_arbiter_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // A single requester still needs a 1-bit ID field
  function automatic int reqIdW(input int numReq);
    return (numReq > 2) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/ripplecarry_adder.sv
// Plain ripple-carry adder: the carry walks bit by bit from LSB to MSB,
// which is why the arbiter holds operands stable while it settles.
module ripplecarry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carryIn_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carryOut_o
);

  logic carry;

  always_comb begin
    sum_o = '0;
    carry = carryIn_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
  end

  assign carryOut_o = carry;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches from the requester after the last winner,
// wrapping around, and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    lastGrant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grantIdx_o
);

  int              cand;
  logic [ID_W-1:0] candIdx;
  logic            found;

  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    found      = 1'b0;
    cand       = 0;
    candIdx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand    = (int'(lastGrant_i) + i) % NUM_REQ;
      candIdx = ID_W'(cand);
      if (!found && valid_i[candIdx]) begin
        found            = 1'b1;
        grant_o[candIdx] = 1'b1;
        grantIdx_o       = candIdx;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one ripple-carry adder among NUM_REQ requesters with round-robin
// grants and a valid/ready response. Define ADDER_ARB_SAT_EN to saturate sums.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int REQ_ID_W      = reqIdW(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  data_t [NUM_REQ-1:0] req_a,
  input  data_t [NUM_REQ-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output data_t               rsp_sum,
  output logic                rsp_carry,
  output logic [REQ_ID_W-1:0] rsp_id,
  output logic                busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  if (SETTLE_CYCLES < 1) begin : g_badSettle
    $error("adder_arbiter: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_REQ < 2) begin : g_badNumReq
    $error("adder_arbiter: NUM_REQ must be >= 2");
  end

  arb_state_t          state_q;
  data_t               opA_q;
  data_t               opB_q;
  logic [REQ_ID_W-1:0] opId_q;
  logic [CNT_W-1:0]    settleCnt_q;
  logic [REQ_ID_W-1:0] lastGrant_q;
  logic                rspValid_q;
  data_t               rspSum_q;
  data_t               rspSum_d;
  logic                rspCarry_q;
  logic [REQ_ID_W-1:0] rspId_q;

  logic [NUM_REQ-1:0]  grant;
  logic [REQ_ID_W-1:0] grantIdx;
  data_t               adderSum;
  logic                adderCarry;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (REQ_ID_W)
  ) u_rrArbiter (
    .valid_i     (req_valid),
    .lastGrant_i (lastGrant_q),
    .grant_o     (grant),
    .grantIdx_o  (grantIdx)
  );

  // The adder only ever sees the captured operands, never the live request bus
  ripplecarry_adder #(
    .WIDTH (DATA_WIDTH)
  ) u_adder (
    .a_i        (opA_q),
    .b_i        (opB_q),
    .carryIn_i  (1'b0),
    .sum_o      (adderSum),
    .carryOut_o (adderCarry)
  );

`ifdef ADDER_ARB_SAT_EN
  assign rspSum_d = adderCarry ? '1 : adderSum;
`else
  assign rspSum_d = adderSum;
`endif

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rspValid_q;
  assign rsp_sum   = rspSum_q;
  assign rsp_carry = rspCarry_q;
  assign rsp_id    = rspId_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      opId_q      <= '0;
      settleCnt_q <= '0;
      lastGrant_q <= REQ_ID_W'(NUM_REQ - 1);
      rspValid_q  <= 1'b0;
      rspSum_q    <= '0;
      rspCarry_q  <= 1'b0;
      rspId_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            opA_q       <= req_a[grantIdx];
            opB_q       <= req_b[grantIdx];
            opId_q      <= grantIdx;
            settleCnt_q <= CNT_W'(SETTLE_CYCLES);
            lastGrant_q <= grantIdx;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          if (settleCnt_q == CNT_W'(1)) begin
            rspSum_q   <= rspSum_d;
            rspCarry_q <= adderCarry;
            rspId_q    <= opId_q;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            settleCnt_q <= settleCnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (SETTLE_CYCLES=1 and 4 instances);
// expected sums follow ADDER_ARB_SAT_EN when it is defined.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

`ifdef ADDER_ARB_SAT_EN
  localparam data_t OVF_SUM = 8'hFF;
  localparam data_t S80_SUM = 8'hFF;
`else
  localparam data_t OVF_SUM = 8'h01;
  localparam data_t S80_SUM = 8'h00;
`endif

  typedef struct packed {
    data_t          sum;
    logic           carry;
    logic [IDW-1:0] id;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   reqValid, reqReady;
  data_t [N-1:0]  reqA, reqB;
  logic           rspValid, rspReady, rspCarry, busy;
  data_t          rspSum;
  logic [IDW-1:0] rspId;

  logic [N-1:0]   reqValid4, reqReady4;
  data_t [N-1:0]  reqA4, reqB4;
  logic           rspValid4, rspReady4, rspCarry4, busy4;
  data_t          rspSum4;
  logic [IDW-1:0] rspId4;

  rsp_t expQ[$];
  rsp_t expQ4[$];
  rsp_t expRsp, expRsp4;
  int   testsRun = 0;
  int   testsFailed = 0;

  adder_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_sum(rspSum), .rsp_carry(rspCarry), .rsp_id(rspId), .busy(busy)
  );

  adder_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid4), .req_ready(reqReady4),
    .req_a(reqA4), .req_b(reqB4), .rsp_valid(rspValid4), .rsp_ready(rspReady4),
    .rsp_sum(rspSum4), .rsp_carry(rspCarry4), .rsp_id(rspId4), .busy(busy4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor for the SETTLE_CYCLES=1 instance: pops on every response handshake
  always @(negedge clk) begin
    if (rst_n && rspValid && rspReady) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedRsp: got id %0d sum 0x%0h, required no response",
                 rspId, rspSum);
      end else begin
        expRsp = expQ.pop_front();
        checkOutput("rspSum", 32'(rspSum), 32'(expRsp.sum));
        checkOutput("rspCarry", 32'(rspCarry), 32'(expRsp.carry));
        checkOutput("rspId", 32'(rspId), 32'(expRsp.id));
      end
    end
  end

  // Monitor for the SETTLE_CYCLES=4 instance
  always @(negedge clk) begin
    if (rst_n && rspValid4 && rspReady4) begin
      if (expQ4.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedRsp4: got id %0d sum 0x%0h, required no response",
                 rspId4, rspSum4);
      end else begin
        expRsp4 = expQ4.pop_front();
        checkOutput("rspSum4", 32'(rspSum4), 32'(expRsp4.sum));
        checkOutput("rspCarry4", 32'(rspCarry4), 32'(expRsp4.carry));
        checkOutput("rspId4", 32'(rspId4), 32'(expRsp4.id));
      end
    end
  end

  task automatic waitReady(input int id, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reqReady[id]) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !rspValid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain", 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input int id, input data_t a, input data_t b,
                               input data_t eSum, input logic eCarry);
    @(posedge clk); #1;
    reqA[id] = a;
    reqB[id] = b;
    reqValid[id] = 1'b1;
    expQ.push_back('{sum: eSum, carry: eCarry, id: IDW'(id)});
    waitReady(id, "grantSeen");
    checkOutput("grantOneHot", 32'(reqReady), 32'(4'b0001 << id));
    @(posedge clk); #1;
    reqValid[id] = 1'b0;
    @(negedge clk);
    checkOutput("execBusy", 32'(busy), 32'd1);
    checkOutput("execNoRsp", 32'(rspValid), 32'd0);
    checkOutput("execNoReady", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("rspValidRise", 32'(rspValid), 32'd1);
    waitDrain();
  endtask

  logic [N-1:0] rrOrder [5];
  int           grants;
  int           lat;
  bit           seen4;

  initial begin
    rrOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    reqValid = '0; reqA = '0; reqB = '0; rspReady = 1'b1;
    reqValid4 = '0; reqA4 = '0; reqB4 = '0; rspReady4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetRspValid", 32'(rspValid), 32'd0);
    checkOutput("resetRspSum", 32'(rspSum), 32'd0);
    checkOutput("resetRspCarry", 32'(rspCarry), 32'd0);
    checkOutput("resetRspId", 32'(rspId), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetReqReady", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] single request and overflow");
    applyStimulus(2, 8'h12, 8'h34, 8'h46, 1'b0);
    applyStimulus(1, 8'hFF, 8'h02, OVF_SUM, 1'b1);
    applyStimulus(3, 8'h10, 8'h20, 8'h30, 1'b0);

    $display("[TB] round-robin with all requesters active");
    @(posedge clk); #1;
    reqA = {8'hA0, 8'h7F, 8'h10, 8'h01};
    reqB = {8'h05, 8'h01, 8'h20, 8'h02};
    expQ.push_back('{sum: 8'h03, carry: 1'b0, id: 2'd0});
    expQ.push_back('{sum: 8'h30, carry: 1'b0, id: 2'd1});
    expQ.push_back('{sum: 8'h80, carry: 1'b0, id: 2'd2});
    expQ.push_back('{sum: 8'hA5, carry: 1'b0, id: 2'd3});
    expQ.push_back('{sum: 8'h03, carry: 1'b0, id: 2'd0});
    reqValid = 4'hF;
    grants = 0;
    for (int i = 0; i < 200 && grants < 5; i++) begin
      @(negedge clk);
      if (|reqReady) begin
        checkOutput("rrGrant", 32'(reqReady), 32'(rrOrder[grants]));
        grants++;
      end
    end
    checkOutput("rrGrantCount", 32'(grants), 32'd5);
    @(posedge clk); #1;
    reqValid = '0;
    waitDrain();

    $display("[TB] back-pressure");
    @(posedge clk); #1;
    rspReady = 1'b0;
    reqA[0] = 8'h55; reqB[0] = 8'h22; reqValid[0] = 1'b1;
    expQ.push_back('{sum: 8'h77, carry: 1'b0, id: 2'd0});
    waitReady(0, "bpGrant0");
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    reqA[1] = 8'h01; reqB[1] = 8'h01; reqValid[1] = 1'b1;
    expQ.push_back('{sum: 8'h02, carry: 1'b0, id: 2'd1});
    lat = 0;
    for (int i = 0; i < 20 && !rspValid; i++) @(negedge clk);
    checkOutput("bpRspValid", 32'(rspValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpHoldSum", 32'(rspSum), 32'h77);
      checkOutput("bpHoldId", 32'(rspId), 32'd0);
      checkOutput("bpHoldValid", 32'(rspValid), 32'd1);
      checkOutput("bpNoGrant", 32'(reqReady), 32'd0);
      checkOutput("bpBusy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rspReady = 1'b1;
    waitReady(1, "bpGrant1");
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    waitDrain();

    $display("[TB] reset during EXEC");
    @(posedge clk); #1;
    reqA[2] = 8'h11; reqB[2] = 8'h22; reqValid[2] = 1'b1;
    waitReady(2, "rstGrant");
    @(posedge clk); #1;
    reqValid[2] = 1'b0;
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    checkOutput("preRstSum", 32'(rspSum), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstRspValid", 32'(rspValid), 32'd0);
    checkOutput("rstRspSum", 32'(rspSum), 32'd0);
    checkOutput("rstRspCarry", 32'(rspCarry), 32'd0);
    checkOutput("rstRspId", 32'(rspId), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reqA[0] = 8'h0F; reqB[0] = 8'h01;
    reqValid = 4'hF;
    expQ.push_back('{sum: 8'h10, carry: 1'b0, id: 2'd0});
    @(negedge clk);
    checkOutput("postRstPriority", 32'(reqReady), 32'h1);
    @(posedge clk); #1;
    reqValid = '0;
    waitDrain();

    $display("[TB] SETTLE_CYCLES=4 instance");
    @(posedge clk); #1;
    reqA4[0] = 8'h80; reqB4[0] = 8'h80; reqValid4[0] = 1'b1;
    expQ4.push_back('{sum: S80_SUM, carry: 1'b1, id: 2'd0});
    seen4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reqReady4[0]) begin
        seen4 = 1'b1;
        break;
      end
    end
    checkOutput("settle4Grant", 32'(seen4), 32'd1);
    @(posedge clk); #1;
    reqValid4 = '0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rspValid4) break;
      lat++;
    end
    checkOutput("settle4Latency", 32'(lat), 32'd4);
    repeat (3) @(negedge clk);
    checkOutput("settle4Drained", 32'(expQ4.size()), 32'd0);
    checkOutput("finalDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
